// File: rtl/hilo_muldiv_pkg.sv
// Shared op codes, FSM states and sizing for the iterative HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_STEPS = MD_WIDTH;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_md_step.sv
// One iteration of the unsigned shift-add multiplier or restoring divider.
// acc is {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
module hilo_muldiv_md_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    ge     = (rem_sh >= {1'b0, operand});
    // The remainder after a successful subtract is below the divisor, so WIDTH bits suffice.
    diff   = rem_sh[WIDTH-1:0] - operand;
    if (is_div) begin
      acc_next = ge ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative 32-step multiply/divide unit holding the architectural HI/LO registers.
// Operands run as magnitudes; signs are reapplied in the FIX state.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  md_state_e          state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   operand;
  logic               op_div, neg_res, neg_rem, zero_div;

  md_op_e             op_in;
  logic               in_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  hilo_muldiv_md_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .is_div   (op_div),
    .acc_next (acc_next)
  );

  always_comb begin
    op_in  = md_op_e'(op);
    in_div = md_is_div(op_in);
    a_neg  = md_is_signed(op_in) & src_a[WIDTH-1];
    b_neg  = md_is_signed(op_in) & src_b[WIDTH-1];
    a_mag  = a_neg ? -src_a : src_a;
    b_mag  = b_neg ? -src_b : src_b;
  end

  // Sign fix-up: quotient/product follow sign(a)^sign(b), remainder follows the dividend.
  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (op_div) begin
      fix_hi = rem;
      fix_lo = zero_div ? '1 : quo;
    end else begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      zero_div <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // A simultaneous mt* write is dropped; the completing op owns HI/LO.
            acc      <= in_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            operand  <= in_div ? b_mag : a_mag;
            op_div   <= in_div;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            zero_div <= in_div & (src_b == '0);
            count    <= '0;
            state    <= ST_CALC;
          end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        ST_CALC: begin
          acc <= acc_next;
          if (count == LAST_STEP) state <= ST_FIX;
          else                    count <= count + 1'b1;
        end
        ST_FIX: begin
          hi       <= fix_hi;
          lo       <= fix_lo;
          done     <= 1'b1;
          div_zero <= zero_div;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state != ST_IDLE);
  assign stall = busy & (rd_en | wr_hi | wr_lo | start);

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner vectors, in-flight hazards,
// reset abort and randomized ops against a plain-arithmetic reference model.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, wr_hi, wr_lo, rd_en;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wr_data;
  logic        busy, stall, done, div_zero;
  logic [31:0] hi, lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit arithmetic straight from the op definitions.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    logic [63:0] p;
    longint      sa, sb, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    edz = 1'b0;
    p   = '0;
    if (o == 2'd0) p = 64'(sa * sb);
    if (o == 2'd1) p = {32'b0, a} * {32'b0, b};
    if (o < 2'd2) begin
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      eh = a; el = 32'hFFFF_FFFF; edz = 1'b1;
    end else if (o == 2'd2) begin
      q = sa / sb; r = sa % sb;
      eh = r[31:0]; el = q[31:0];
    end else begin
      eh = a % b; el = a / b;
    end
  endfunction

  // Called at a negedge; returns at the negedge of the first busy cycle.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n0 = busy cycles already observed; returns at the negedge of the done cycle.
  task automatic finish(input string tag, input int n0, input logic [31:0] eh,
                        input logic [31:0] el, input logic edz);
    int n    = n0;
    bit held = 1'b1;
    while (busy && n < 100) begin
      n++;
      if (hi !== exp_hi || lo !== exp_lo) held = 1'b0;
      @(negedge clk);
    end
    check({tag, "/busy_cycles"}, 64'(n), 64'd33);
    check({tag, "/hold"}, 64'(held), 64'd1);
    check({tag, "/done"}, 64'(done), 64'd1);
    check({tag, "/div_zero"}, 64'(div_zero), 64'(edz));
    check({tag, "/hi"}, 64'(hi), 64'(eh));
    check({tag, "/lo"}, 64'(lo), 64'(el));
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eh, el;
    logic        edz;
    model(o, a, b, eh, el, edz);
    launch(o, a, b);
    finish(tag, 0, eh, el, edz);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, h, l;
    logic        dz;
  } vec_t;

  vec_t vecs[8] = '{
    '{2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0},
    '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
    '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0},
    '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0},
    '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0},
    '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0},
    '{2'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1},
    '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1}
  };

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, d;
    rst = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; rd_en = 1'b0;
    op = 2'd0; src_a = '0; src_b = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/div_zero", 64'(div_zero), 64'd0);
    check("reset/hi", 64'(hi), 64'd0);
    check("reset/lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Corner vectors, each launched on the previous done cycle (back-to-back).
    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      finish($sformatf("vec%0d", i), 0, vecs[i].h, vecs[i].l, vecs[i].dz);
    end

    // mthi/mtlo in idle, single and dual strobe.
    wr_hi = 1'b1; wr_data = 32'h0000_1234;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi/hi", 64'(hi), 64'h1234);
    check("mthi/lo", 64'(lo), 64'(exp_lo));
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hCAFE_F00D;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mt_both/hi", 64'(hi), 64'hCAFE_F00D);
    check("mt_both/lo", 64'(lo), 64'hCAFE_F00D);
    exp_hi = 32'hCAFE_F00D; exp_lo = 32'hCAFE_F00D;

    // start with a simultaneous write (write dropped), then hazards while busy.
    wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
    launch(2'd0, 32'h0000_0007, 32'hFFFF_FFFD);
    wr_hi = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd1; src_a = 32'h1111_1111; src_b = 32'h2222_2222;
    #1 check("busy_start/stall", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b1; wr_data = 32'h0000_1234;
    #1 check("busy_mthi/stall", 64'(stall), 64'd1);
    @(negedge clk);
    wr_hi = 1'b0; rd_en = 1'b1;
    #1 check("busy_rd/stall", 64'(stall), 64'd1);
    @(negedge clk);
    rd_en = 1'b0;
    finish("hazard", 7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    rd_en = 1'b1;
    #1 check("idle_rd/stall", 64'(stall), 64'd0);
    rd_en = 1'b0;

    // Reset ten cycles into a divide aborts with no HI/LO write.
    launch(2'd2, 32'h0000_0064, 32'h0000_0007);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort/busy", 64'(busy), 64'd0);
    check("abort/hi", 64'(hi), 64'd0);
    check("abort/lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    run_op("post_reset", 2'd0, 32'd3, 32'd4);
    check("post_reset/const_lo", 64'(lo), 64'hC);

    // Randomized ops with occasional corner operands, gaps and mt* writes.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        d = $urandom;
        wr_lo = 1'b1; wr_data = d;
        @(negedge clk);
        wr_lo = 1'b0;
        check($sformatf("rnd%0d/mtlo", i), 64'(lo), 64'(d));
        exp_lo = d;
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
    end

    @(negedge clk);
    check("final/done_pulse", 64'(done), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit and HI/LO register pair that consumes the mult/div ops and supplies the mfhi/mflo/mthi/mtlo path of the pipeline. It replaces single-cycle hi/lo production with an iterative 32-step shift-add multiplier and restoring divider, and holds the architectural HI/LO state. While an operation is in flight it reports busy so the hazard unit can stall dependent HI/LO accesses. It sits beside the EX-stage ALU, with operands taken from the same src_a/src_b buses.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is verified.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch op on src_a/src_b; accepted only when busy=0.
- op  in  2  `MD_MULT=0, `MD_MULTU=1, `MD_DIV=2, `MD_DIVU=3.
- src_a  in  WIDTH  multiplicand / dividend.
- src_b  in  WIDTH  multiplier / divisor.
- wr_hi, wr_lo  in  1  mthi/mtlo write strobes.
- wr_data  in  WIDTH  mthi/mtlo data.
- rd_en  in  1  mfhi/mflo request.
- busy  out  1  op in flight.
- stall  out  1  = busy & (rd_en | wr_hi | wr_lo | start).
- done  out  1  one-cycle pulse; new hi/lo visible this cycle.
- div_zero  out  1  pulses with done when a divide had src_b=0.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE + start: capture |a|, |b| (signed ops) or raw (unsigned ops), result signs, op, and a zero-divisor flag; count=0; go to CALC.
- CALC: one step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 1 quotient bit per step.
  - After step 31 go to FIX.
- FIX: apply signs and write HI/LO, pulse done, return to IDLE.
  - Multiply: product negated if sign(a)^sign(b) on MULT; hi = upper 32 bits, lo = lower 32 bits.
  - Divide: quotient negated if sign(a)^sign(b); remainder takes the dividend's sign. lo = quotient, hi = remainder.
- Divide by zero (DIV/DIVU): lo=FFFFFFFF, hi=src_a as captured; div_zero=1 with done. No further special-casing.
- DIV 80000000/FFFFFFFF: lo=80000000, hi=0. This is the natural result of 32-bit unsigned magnitudes.
- start while busy: ignored; stall asserted.
- wr_hi/wr_lo while busy: ignored; stall asserted.
- wr_hi/wr_lo in IDLE: write on the edge; both may be set in the same cycle.
- start and wr_* together in IDLE: start taken, write dropped. The completed op overwrites HI/LO anyway.
- hi/lo hold their old values throughout CALC; only FIX or an mt* write changes them.

## Timing
- Reset: state IDLE; hi, lo, count, accumulators = 0; busy, done, div_zero, stall = 0.
- Reset mid-operation aborts immediately to the reset state; no partial HI/LO write.
- Start accepted on edge E0. busy=1 from the cycle after E0 through the FIX cycle (33 cycles).
- done=1 and new hi/lo visible in the cycle after the FIX edge, 34 cycles after E0. busy=0 in that cycle.
- A new start on the done cycle is accepted (back-to-back, no bubble).
- mt* write: hi/lo update visible the cycle after the strobe edge.
- hi/lo outputs are registers, with no combinational path from inputs.

## Structure
- `MD_* op codes and the iteration count (32) go in the shared project defines header, alongside the ALU codes.
- One natural sub-module: md_step, combinational. It performs one multiply add-shift or divide subtract-shift on {acc, operand, op}. The FSM and registers stay in hilo_muldiv.

## Test plan
- MULT 7 × FFFFFFFD → at cycle E0+34: done=1, hi=FFFFFFFF, lo=FFFFFFEB. busy high for exactly 33 cycles.
- MULTU FFFFFFFF × FFFFFFFF → hi=FFFFFFFE, lo=00000001. Same op as MULT → hi=0, lo=1.
- DIV FFFFFFF9 / 2 → lo=FFFFFFFD, hi=FFFFFFFF. DIVU FFFFFFF9 / 2 → lo=7FFFFFFC, hi=1.
- DIV 80000000 / FFFFFFFF → lo=80000000, hi=0, div_zero=0. DIVU 5 / 0 → lo=FFFFFFFF, hi=5, div_zero=1 with done.
- During a busy op:
  - second start → stall=1, ignored, original result intact.
  - wr_hi with 1234 → ignored.
  - rd_en → stall=1.
  - After done: mthi 1234 → hi=1234 next cycle. Back-to-back start on the done cycle is accepted.
- rst asserted 10 cycles into a DIV → busy=0, hi=lo=0 immediately. A following MULT 3×4 gives lo=C, hi=0.
